imm_table: RTL



---
 rtl/imm_table_if.sv | 26 ++
 rtl/imm_table.sv | 121 ++++++++++++
 2 files changed

// File: rtl/imm_table_if.sv
// Load-immediate table bus: read request/select, runtime write port and
// the registered immediate returned to the register-file write mux.
interface imm_table_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              rd_req;
    logic [ADDR_W:0]   sel;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              ready;
    logic [DATA_W-1:0] dat_out;
    logic              dat_valid;
    logic              wr_drop;

    modport master (
        output rd_req, sel, wr_en, wr_addr, wr_data,
        input  ready, dat_out, dat_valid, wr_drop
    );

    modport slave (
        input  rd_req, sel, wr_en, wr_addr, wr_data,
        output ready, dat_out, dat_valid, wr_drop
    );
endinterface

// File: rtl/imm_table.sv
// Programmable immediate-constant table with post-reset default sweep.
// IMM_TABLE_SIGN_EXT_EN: sign-extend the direct immediate instead of zero-extend.
module imm_table #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    imm_table_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_tab [DEPTH];
    logic [DATA_W-1:0] r_dat_out;
    logic              r_dat_valid;
    logic              r_wr_drop;

    logic              w_run;
    logic              w_rd;
    logic              w_tsel;
    logic [ADDR_W-1:0] w_idx;
    logic [DATA_W-1:0] w_imm;
    logic [DATA_W-1:0] w_rd_val;

    function automatic logic [DATA_W-1:0] f_dflt(input logic [ADDR_W-1:0] a);
        logic [7:0] v;
        case (int'(a))
            0:       v = 8'hF1;
            1:       v = 8'h80;
            2:       v = 8'h81;
            3:       v = 8'hC8;
            4:       v = 8'h82;
            5:       v = 8'h26;
            6:       v = 8'hD7;
            7:       v = 8'h40;
            8:       v = 8'h00;
            9:       v = 8'hF5;
            10:      v = 8'h80;
            11:      v = 8'h4A;
            12:      v = 8'hF0;
            13:      v = 8'hF9;
            14:      v = 8'hFF;
            15:      v = 8'hF4;
            default: v = 8'h00;
        endcase
        return DATA_W'($signed(v));
    endfunction

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_INIT)
                r_cnt <= r_cnt + ADDR_W'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_INIT:  if (r_cnt == '1) w_state_nxt = S_RUN;
            default: w_state_nxt = r_state;
        endcase
    end

    assign w_run  = (r_state == S_RUN);
    assign w_rd   = w_run && bus.rd_req;
    assign w_tsel = bus.sel[ADDR_W];
    assign w_idx  = bus.sel[ADDR_W-1:0];

`ifdef IMM_TABLE_SIGN_EXT_EN
    assign w_imm = DATA_W'($signed(w_idx));
`else
    assign w_imm = DATA_W'(w_idx);
`endif

    // Write-first: a same-cycle write to the read address is forwarded.
    always_comb begin
        w_rd_val = w_imm;
        if (w_tsel) begin
            if (bus.wr_en && bus.wr_addr == w_idx)
                w_rd_val = bus.wr_data;
            else
                w_rd_val = r_tab[w_idx];
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            if (r_state == S_INIT)
                r_tab[r_cnt] <= f_dflt(r_cnt);
            else if (bus.wr_en)
                r_tab[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_dat_out   <= '0;
            r_dat_valid <= 1'b0;
            r_wr_drop   <= 1'b0;
        end else begin
            r_dat_valid <= w_rd;
            r_wr_drop   <= !w_run && bus.wr_en;
            if (w_rd)
                r_dat_out <= w_rd_val;
        end
    end

    assign bus.ready     = w_run;
    assign bus.dat_out   = r_dat_out;
    assign bus.dat_valid = r_dat_valid;
    assign bus.wr_drop   = r_wr_drop;
endmodule
